// File: rtl/rca_serial_if.sv
// rtl/rca_serial_if.sv - request/response bundle for the digit-serial adder/subtractor
//
// Purpose: carries one operation request (Start, Sub, A, B, Cin) towards the
// adder and its status/results (Busy, Done, So, Cout, Ovf) back to the requester.
// Ports (signals):
//   Start, Sub, Cin   master -> slave   request strobe, op select, carry/borrow in
//   A, B [WIDTH]      master -> slave   operands
//   Busy, Done        slave -> master   operation in progress, completion pulse
//   So [WIDTH]        slave -> master   registered sum/difference
//   Cout, Ovf         slave -> master   raw MSB carry, two's-complement overflow
interface rca_serial_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] So;
    logic             Cout;
    logic             Ovf;

    modport master (
        output Start, Sub, A, B, Cin,
        input  Busy, Done, So, Cout, Ovf
    );

    modport slave (
        input  Start, Sub, A, B, Cin,
        output Busy, Done, So, Cout, Ovf
    );
endinterface

// File: rtl/rca_serial.sv
// rtl/rca_serial.sv - digit-serial ripple-carry adder/subtractor
//
// Purpose: reuses one DIGIT-bit adder chain over NDIG = WIDTH/DIGIT cycles,
// carrying between digits through a 1-bit register, LSB digit first.
// Ports:
//   CLK    in   rising-edge clock
//   RST_n  in   asynchronous active-low reset
//   bus    slave modport of rca_serial_if (request in, Busy/Done/results out)
module rca_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic         CLK,
    input  logic         RST_n,
    rca_serial_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("rca_serial: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;

    logic             done_r;
    logic [WIDTH-1:0] so_r;
    logic             cout_r;
    logic             ovf_r;

    logic [DIGIT:0]   sum_full;
    logic             c_msb_in;
    logic [WIDTH-1:0] res_next;

    // One digit of the chain. The carry into the slice MSB is recovered from
    // the sum bit, so overflow needs no separate partial adder.
    always_comb begin
        sum_full = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
        c_msb_in = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ sum_full[DIGIT-1];
        // New digit enters at the top; after NDIG digits the LSB digit sits at bit 0.
        res_next = (res >> DIGIT) | (WIDTH'(sum_full[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            done_r <= 1'b0;
            so_r   <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.Start) begin
                    state <= RUN;
                    a_sh  <= bus.A;
                    // Subtract as A + ~B + ~Cin, i.e. A - B - Cin.
                    b_sh  <= bus.B ^ {WIDTH{bus.Sub}};
                    carry <= bus.Cin ^ bus.Sub;
                    cnt   <= '0;
                    res   <= '0;
                end
            end else begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                res   <= res_next;
                carry <= sum_full[DIGIT];
                cnt   <= cnt + CW'(1);
                if (cnt == LAST) begin
                    state  <= IDLE;
                    so_r   <= res_next;
                    cout_r <= sum_full[DIGIT];
                    ovf_r  <= c_msb_in ^ sum_full[DIGIT];
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign bus.Busy = (state == RUN);
    assign bus.Done = done_r;
    assign bus.So   = so_r;
    assign bus.Cout = cout_r;
    assign bus.Ovf  = ovf_r;
endmodule

// File: tb/tb_rca_serial.sv
// tb/tb_rca_serial.sv - self-checking bench for rca_serial over four WIDTH/DIGIT shapes
module tb_rca_serial;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rca_serial_if #(.WIDTH(16)) i0 ();
    rca_serial_if #(.WIDTH(6))  i1 ();
    rca_serial_if #(.WIDTH(8))  i2 ();
    rca_serial_if #(.WIDTH(32)) i3 ();

    rca_serial #(.WIDTH(16), .DIGIT(4)) u0 (.CLK(clk), .RST_n(rst_n), .bus(i0));
    rca_serial #(.WIDTH(6),  .DIGIT(6)) u1 (.CLK(clk), .RST_n(rst_n), .bus(i1));
    rca_serial #(.WIDTH(8),  .DIGIT(1)) u2 (.CLK(clk), .RST_n(rst_n), .bus(i2));
    rca_serial #(.WIDTH(32), .DIGIT(8)) u3 (.CLK(clk), .RST_n(rst_n), .bus(i3));

    typedef struct {
        logic [31:0] so;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        busy;
        logic        done;
        logic [31:0] so;
        logic        cout;
        logic        ovf;
    } out_t;

    int   wd [4] = '{16, 6, 8, 32};
    int   nd [4] = '{4, 1, 8, 4};
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   busycnt;
    exp_t sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic sub,
                         input logic [31:0] a, input logic [31:0] b, input logic cin);
        case (sel)
            0: begin i0.Start = st; i0.Sub = sub; i0.A = a[15:0]; i0.B = b[15:0]; i0.Cin = cin; end
            1: begin i1.Start = st; i1.Sub = sub; i1.A = a[5:0];  i1.B = b[5:0];  i1.Cin = cin; end
            2: begin i2.Start = st; i2.Sub = sub; i2.A = a[7:0];  i2.B = b[7:0];  i2.Cin = cin; end
            default: begin i3.Start = st; i3.Sub = sub; i3.A = a; i3.B = b; i3.Cin = cin; end
        endcase
    endtask

    function automatic out_t rd(input int sel);
        out_t o;
        case (sel)
            0: begin o.busy = i0.Busy; o.done = i0.Done; o.so = 32'(i0.So); o.cout = i0.Cout; o.ovf = i0.Ovf; end
            1: begin o.busy = i1.Busy; o.done = i1.Done; o.so = 32'(i1.So); o.cout = i1.Cout; o.ovf = i1.Ovf; end
            2: begin o.busy = i2.Busy; o.done = i2.Done; o.so = 32'(i2.So); o.cout = i2.Cout; o.ovf = i2.Ovf; end
            default: begin o.busy = i3.Busy; o.done = i3.Done; o.so = i3.So; o.cout = i3.Cout; o.ovf = i3.Ovf; end
        endcase
        return o;
    endfunction

    task automatic step(input int sel);
        out_t o;
        @(posedge clk);
        #1;
        lat++;
        o = rd(sel);
        if (o.busy) busycnt++;
    endtask

    // Drives one request, pushes the reference result and takes the Start edge.
    task automatic start_op(input int sel, input logic sub, input logic [31:0] a,
                            input logic [31:0] b, input logic cin);
        logic [63:0] m, am, bb, s;
        exp_t        e;
        out_t        o;
        int          w;
        w  = wd[sel];
        m  = (64'd1 << w) - 64'd1;
        am = {32'd0, a} & m;
        bb = sub ? (~{32'd0, b} & m) : ({32'd0, b} & m);
        s  = am + bb + 64'(cin ^ sub);
        e.so   = s[31:0] & m[31:0];
        e.cout = s[w];
        e.ovf  = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        sb.push_back(e);
        drive(sel, 1'b1, sub, a, b, cin);
        lat = 0;
        busycnt = 0;
        step(sel);
        lat = 0;
        o = rd(sel);
        check("busy_after_start", o.busy, 1);
        check("done_low_after_start", o.done, 0);
        drive(sel, 1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom));
    endtask

    task automatic wait_done(input int sel, input string tag);
        out_t o;
        exp_t e;
        o = rd(sel);
        while (!o.done && lat < nd[sel] + 4) begin
            step(sel);
            o = rd(sel);
        end
        check({tag, "_latency"}, lat, nd[sel]);
        if (o.done) begin
            check({tag, "_busy_at_done"}, o.busy, 0);
            check({tag, "_busy_cycles"}, busycnt, nd[sel]);
            check({tag, "_pending"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_so"}, o.so, e.so);
                check({tag, "_cout"}, o.cout, e.cout);
                check({tag, "_ovf"}, o.ovf, e.ovf);
            end
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        out_t o;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o = rd(0);
        check("rst_busy", o.busy, 0);
        check("rst_done", o.done, 0);
        check("rst_so", o.so, 0);
        check("rst_cout", o.cout, 0);
        check("rst_ovf", o.ovf, 0);
        rst_n = 1'b1;

        // First Start is taken at the first edge that sees RST_n high.
        start_op(0, 1'b0, 32'h1234, 32'h4321, 1'b0);
        wait_done(0, "add_5555");
        step(0);
        o = rd(0);
        check("done_single_pulse", o.done, 0);
        check("so_holds", o.so, 32'h5555);

        start_op(0, 1'b0, 32'hFFFF, 32'h0001, 1'b0); wait_done(0, "add_ffff_1");
        start_op(0, 1'b0, 32'h7FFF, 32'h0001, 1'b0); wait_done(0, "add_7fff_1");
        start_op(0, 1'b0, 32'h0000, 32'h0000, 1'b1); wait_done(0, "add_cin");
        start_op(0, 1'b1, 32'h0005, 32'h0007, 1'b0); wait_done(0, "sub_5_7");
        start_op(0, 1'b1, 32'h8000, 32'h0001, 1'b0); wait_done(0, "sub_8000_1");

        // Start while busy must be ignored.
        start_op(0, 1'b0, 32'h1111, 32'h2222, 1'b0);
        step(0);
        step(0);
        drive(0, 1'b1, 1'b0, 32'hAAAA, 32'h5555, 1'b1);
        step(0);
        drive(0, 1'b0, 1'b1, 32'h0F0F, 32'hF0F0, 1'b0);
        wait_done(0, "ignored_start");
        step(0);
        o = rd(0);
        check("no_rerun_busy", o.busy, 0);
        check("no_rerun_so", o.so, 32'h3333);

        // Start in the Done cycle is accepted.
        start_op(0, 1'b1, 32'h0100, 32'h0001, 1'b1); wait_done(0, "back1");
        start_op(0, 1'b0, 32'h0F0F, 32'h00F1, 1'b1); wait_done(0, "back2");

        // Reset in the middle of a run.
        start_op(0, 1'b0, 32'hABCD, 32'h1357, 1'b0);
        step(0);
        step(0);
        rst_n = 1'b0;
        #1;
        o = rd(0);
        check("midrst_busy", o.busy, 0);
        check("midrst_done", o.done, 0);
        check("midrst_so", o.so, 0);
        check("midrst_cout", o.cout, 0);
        check("midrst_ovf", o.ovf, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(0);
            o = rd(0);
            check("no_done_after_rst", o.done, 0);
        end
        start_op(0, 1'b1, 32'h4000, 32'h0123, 1'b1); wait_done(0, "after_rst");

        for (int s = 1; s < 4; s++) begin
            for (int k = 0; k < 1000; k++) begin
                start_op(s, 1'($urandom), $urandom, $urandom, 1'($urandom));
                wait_done(s, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
